// File: rtl/conv_unit_sched.sv
// conv_unit_sched: round-robin scheduler sharing one reverse-conversion
// correction unit (group decoder + fixed-latency shift/ALU pipeline)
// between two requesters, each allowed one outstanding op.
module conv_unit_sched #(
    parameter int unsigned N   = 3,
    parameter int unsigned LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    // request channel 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2*N+1:0]   req0_a,
    input  logic [2*N+1:0]   req0_b,
    // request channel 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2*N+1:0]   req1_a,
    input  logic [2*N+1:0]   req1_b,
    // shared group decoder
    output logic [2*N+1:0]   dec_a,
    output logic [2*N+1:0]   dec_b,
    input  logic [2:0]       dec_sel,
    input  logic [3:0]       dec_aluop,
    input  logic [2:0]       dec_shamt,
    input  logic             dec_shdir,
    // shared datapath
    output logic             dp_issue,
    output logic [2*N+1:0]   dp_a,
    output logic [2*N+1:0]   dp_b,
    output logic [2:0]       dp_sel,
    output logic [3:0]       dp_aluop,
    output logic [2:0]       dp_shamt,
    output logic             dp_shdir,
    input  logic [2*N+1:0]   dp_result,
    // response channel 0
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [2*N+1:0]   rsp0_data,
    output logic [2:0]       rsp0_sel,
    // response channel 1
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [2*N+1:0]   rsp1_data,
    output logic [2:0]       rsp1_sel,
    // status
    output logic             idle
);

    localparam int unsigned W     = 2 * N + 2;
    localparam int unsigned SEL_W = 3;

    // Arbitration state: per-channel busy and last-granted pointer.
    logic [1:0] r_busy;
    logic       r_rr;

    // Channel of the op currently held in the dp_* registers.
    logic       r_dp_tag;

    // Tag pipe tracking ops inside the datapath; stage LAT-1 is the exit.
    logic [LAT-1:0]       r_pipe_vld;
    logic [LAT-1:0]       r_pipe_tag;
    logic [SEL_W*LAT-1:0] r_pipe_sel;

    logic                 w_elig0;
    logic                 w_elig1;
    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_pick1;
    logic [LAT:0]         w_vld_ext;
    logic [LAT:0]         w_tag_ext;
    logic [SEL_W*LAT+SEL_W-1:0] w_sel_ext;
    logic                 w_exit_vld;
    logic                 w_exit_tag;
    logic [SEL_W-1:0]     w_exit_sel;
    logic                 w_hs0;
    logic                 w_hs1;
    logic [W-1:0]         w_result;

    // Eligibility: free channel with a request; flush blocks all grants.
    assign w_elig0 = req0_valid & ~r_busy[0] & ~flush;
    assign w_elig1 = req1_valid & ~r_busy[1] & ~flush;

    // On contention the channel that did not win last time is granted.
    assign w_gnt0 = w_elig0 & (~w_elig1 | r_rr);
    assign w_gnt1 = w_elig1 & (~w_elig0 | ~r_rr);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Decoder sees the granted pair, or the preferred channel when idle.
    assign w_pick1 = w_gnt1 | (~w_gnt0 & ~r_rr);
    assign dec_a   = w_pick1 ? req1_a : req0_a;
    assign dec_b   = w_pick1 ? req1_b : req0_b;

    // Pipe shift inputs, written so LAT=1 needs no special case.
    assign w_vld_ext = {r_pipe_vld, dp_issue};
    assign w_tag_ext = {r_pipe_tag, r_dp_tag};
    assign w_sel_ext = {r_pipe_sel, dp_sel};

    assign w_exit_vld = r_pipe_vld[LAT-1];
    assign w_exit_tag = r_pipe_tag[LAT-1];
    assign w_exit_sel = r_pipe_sel[SEL_W*LAT-1 -: SEL_W];
    assign w_result   = dp_result;

    assign w_hs0 = rsp0_valid & rsp0_ready;
    assign w_hs1 = rsp1_valid & rsp1_ready;

    assign idle = (r_busy == 2'b00) && (r_pipe_vld == '0);

    // Capture decoded control and operands on grant; issue next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_issue <= 1'b0;
            r_dp_tag <= 1'b0;
            dp_a     <= '0;
            dp_b     <= '0;
            dp_sel   <= '0;
            dp_aluop <= '0;
            dp_shamt <= '0;
            dp_shdir <= 1'b0;
        end else begin
            dp_issue <= (w_gnt0 | w_gnt1) & ~flush;
            if (w_gnt0 | w_gnt1) begin
                r_dp_tag <= w_gnt1;
                dp_a     <= dec_a;
                dp_b     <= dec_b;
                dp_sel   <= dec_sel;
                dp_aluop <= dec_aluop;
                dp_shamt <= dec_shamt;
                dp_shdir <= dec_shdir;
            end
        end
    end

    // Tag/valid/sel shift pipe aligned with the datapath latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            r_pipe_tag <= '0;
            r_pipe_sel <= '0;
        end else begin
            if (flush) begin
                r_pipe_vld <= '0;
            end else begin
                r_pipe_vld <= w_vld_ext[LAT-1:0];
            end
            r_pipe_tag <= w_tag_ext[LAT-1:0];
            r_pipe_sel <= w_sel_ext[SEL_W*LAT-1:0];
        end
    end

    // Busy flags and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 2'b00;
            r_rr   <= 1'b1;
        end else if (flush) begin
            r_busy <= 2'b00;
            r_rr   <= 1'b1;
        end else begin
            if (w_gnt0) begin
                r_busy[0] <= 1'b1;
                r_rr      <= 1'b0;
            end else if (w_hs0) begin
                r_busy[0] <= 1'b0;
            end
            if (w_gnt1) begin
                r_busy[1] <= 1'b1;
                r_rr      <= 1'b1;
            end else if (w_hs1) begin
                r_busy[1] <= 1'b0;
            end
        end
    end

    // Response channel 0: load on pipe exit, hold until handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_sel   <= '0;
        end else if (flush) begin
            rsp0_valid <= 1'b0;
        end else if (w_exit_vld && !w_exit_tag) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= w_result;
            rsp0_sel   <= w_exit_sel;
        end else if (w_hs0) begin
            rsp0_valid <= 1'b0;
        end
    end

    // Response channel 1: load on pipe exit, hold until handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_sel   <= '0;
        end else if (flush) begin
            rsp1_valid <= 1'b0;
        end else if (w_exit_vld && w_exit_tag) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= w_result;
            rsp1_sel   <= w_exit_sel;
        end else if (w_hs1) begin
            rsp1_valid <= 1'b0;
        end
    end

    // One outstanding op per channel means a pending response is never overwritten.
    a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
        (w_exit_vld && !flush) |-> !(w_exit_tag ? rsp1_valid : rsp0_valid));

    // At most one grant per cycle.
    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_gnt0 && w_gnt1));

endmodule

// File: tb/tb_conv_unit_sched.sv
// tb_conv_unit_sched: directed bench with a behavioural decoder and
// LAT-cycle datapath computing (a+2)*b mod 2^W.
module tb_conv_unit_sched;

    localparam int unsigned N   = 3;
    localparam int unsigned LAT = 2;
    localparam int unsigned W   = 2 * N + 2;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0] dec_a, dec_b;
    logic [2:0]   dec_sel;
    logic [3:0]   dec_aluop;
    logic [2:0]   dec_shamt;
    logic         dec_shdir;
    logic         dp_issue;
    logic [W-1:0] dp_a, dp_b;
    logic [2:0]   dp_sel;
    logic [3:0]   dp_aluop;
    logic [2:0]   dp_shamt;
    logic         dp_shdir;
    logic [W-1:0] dp_result;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp0_data, rsp1_data;
    logic [2:0]   rsp0_sel, rsp1_sel;
    logic         idle;

    int n_chk;
    int n_err;

    conv_unit_sched #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .dec_a(dec_a), .dec_b(dec_b), .dec_sel(dec_sel), .dec_aluop(dec_aluop),
        .dec_shamt(dec_shamt), .dec_shdir(dec_shdir),
        .dp_issue(dp_issue), .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel),
        .dp_aluop(dp_aluop), .dp_shamt(dp_shamt), .dp_shdir(dp_shdir),
        .dp_result(dp_result),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_sel(rsp0_sel),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_sel(rsp1_sel),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural group decoder.
    assign dec_sel   = dec_b[2:0];
    assign dec_aluop = dec_a[3:0];
    assign dec_shamt = dec_a[6:4];
    assign dec_shdir = dec_b[7];

    function automatic logic [W-1:0] model_f(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [15:0] p;
        p = (16'(a) + 16'd2) * 16'(b);
        return p[W-1:0];
    endfunction

    // Datapath model: result valid exactly LAT=2 cycles after dp_issue, garbage otherwise.
    logic [W-1:0] m_q0, m_q1;
    always @(posedge clk) begin
        m_q0 <= dp_issue ? model_f(dp_a, dp_b) : 8'hEE;
        m_q1 <= m_q0;
    end
    assign dp_result = m_q1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush      = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!idle && k < 30) begin
            nxt();
            mid();
            k++;
        end
        check(tag, 32'(idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic e_r0, e_r1, e_v0, e_v1;
        logic exp_ch1;
        int   g0, g1, ops, cyc;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state
        nxt(); nxt(); mid();
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_outs", 32'({dp_issue, rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 32'd0);
        check("rst_dp", 32'({dp_a, dp_b, dp_sel, dp_aluop}), 32'd0);
        nxt(); rst_n = 1'b1;

        // Single op on ch0
        nxt(); req0_valid = 1'b1; req0_a = 8'h0C; req0_b = 8'h03; mid();
        check("t1_ready", 32'(req0_ready), 32'd1);
        check("t1_dec", 32'({dec_a, dec_b}), 32'h0C03);
        nxt(); req0_valid = 1'b0; mid();
        check("t1_issue", 32'({dp_issue, dp_sel, dp_aluop, dp_shamt, dp_shdir}), 32'({1'b1, 3'd3, 4'hC, 3'd0, 1'b0}));
        check("t1_dp_ops", 32'({dp_a, dp_b}), 32'h0C03);
        nxt(); mid();
        check("t1_issue_once", 32'(dp_issue), 32'd0);
        nxt(); mid();
        check("t1_rsp_early", 32'(rsp0_valid), 32'd0);
        nxt(); rsp0_ready = 1'b1; mid();
        check("t1_rsp", 32'({rsp0_valid, rsp0_data, rsp0_sel}), 32'({1'b1, 8'h2A, 3'd3}));
        nxt(); mid();
        check("t1_done", 32'({rsp0_valid, idle}), 32'b01);

        // Contention right after reset
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        nxt();
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h02;
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h04;
        mid();
        check("t2_gnt0", 32'({req1_ready, req0_ready}), 32'b01);
        nxt(); req0_valid = 1'b0; mid();
        check("t2_gnt1", 32'({req1_ready, req0_ready}), 32'b10);
        check("t2_iss0", 32'({dp_issue, dp_a}), 32'({1'b1, 8'h05}));
        nxt(); req1_valid = 1'b0; mid();
        check("t2_iss1", 32'({dp_issue, dp_a}), 32'({1'b1, 8'h10}));
        nxt(); mid();
        nxt(); mid();
        check("t2_rsp0", 32'({rsp1_valid, rsp0_valid, rsp0_data, rsp0_sel}), 32'({1'b0, 1'b1, 8'h0E, 3'd2}));
        nxt(); mid();
        check("t2_rsp1", 32'({rsp0_valid, rsp1_valid, rsp1_data, rsp1_sel}), 32'({1'b0, 1'b1, 8'h48, 3'd4}));
        wait_idle("t2_idle");

        // Backpressure on ch0 while ch1 keeps cycling
        req0_a = 8'h01; req0_b = 8'h07; req1_a = 8'h03; req1_b = 8'h05;
        for (int c = 0; c < 20; c++) begin
            nxt();
            req0_valid = (c <= 15);
            req1_valid = (c <= 15);
            rsp0_ready = (c >= 14);
            rsp1_ready = 1'b1;
            mid();
            e_r0 = (c == 0) || (c == 15);
            e_r1 = (c == 1) || (c == 6) || (c == 11);
            e_v0 = (c >= 4 && c <= 14) || (c == 19);
            e_v1 = (c == 5) || (c == 10) || (c == 15);
            check("bp_hs", 32'({rsp1_valid, rsp0_valid, req1_ready, req0_ready}), 32'({e_v1, e_v0, e_r1, e_r0}));
            if (e_v0) check("bp_rsp0", 32'({rsp0_data, rsp0_sel}), 32'({8'h15, 3'd7}));
            if (e_v1) check("bp_rsp1", 32'({rsp1_data, rsp1_sel}), 32'({8'h19, 3'd5}));
        end
        wait_idle("bp_idle");

        // Fairness: both always requesting, 20 ops
        exp_ch1 = 1'b1; g0 = 0; g1 = 0; ops = 0; cyc = 0;
        while (ops < 20 && cyc < 200) begin
            nxt();
            req0_valid = 1'b1; req1_valid = 1'b1;
            rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            mid();
            cyc++;
            if (req0_ready || req1_ready) begin
                check("rr_alt", 32'({req1_ready, req0_ready}), exp_ch1 ? 32'b10 : 32'b01);
                exp_ch1 = ~exp_ch1;
                ops++;
                if (req1_ready) g1++; else g0++;
            end
        end
        nxt(); req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_count", {16'(g1), 16'(g0)}, {16'd10, 16'd10});
        wait_idle("rr_idle");

        // Flush with ch0 response pending and ch1 op in flight
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        nxt(); req0_valid = 1'b1; req0_a = 8'h02; req0_b = 8'h01; mid();
        check("fl_acc0", 32'(req0_ready), 32'd1);
        nxt(); req0_valid = 1'b0; mid();
        nxt(); mid();
        nxt(); req1_valid = 1'b1; req1_a = 8'h07; req1_b = 8'h01; mid();
        check("fl_acc1", 32'(req1_ready), 32'd1);
        nxt(); req1_valid = 1'b0; mid();
        check("fl_pending", 32'({rsp0_valid, dp_issue, idle}), 32'b110);
        nxt(); flush = 1'b1; req1_valid = 1'b1; req1_a = 8'h04; req1_b = 8'h02; mid();
        check("fl_noready", 32'({req1_ready, req0_ready}), 32'd0);
        nxt(); flush = 1'b0; mid();
        check("fl_clear", 32'({rsp0_valid, rsp1_valid, dp_issue, idle, req1_ready}), 32'b00011);
        nxt(); req1_valid = 1'b0; mid();
        check("fl_issue", 32'({rsp1_valid, dp_issue, dp_a}), 32'({1'b0, 1'b1, 8'h04}));
        for (int c = 0; c < 2; c++) begin
            nxt(); mid();
            check("fl_late", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        end
        nxt(); mid();
        check("fl_new_rsp", 32'({rsp1_valid, rsp1_data}), 32'({1'b1, 8'h0C}));
        rsp0_ready = 1'b1;
        wait_idle("fl_idle");

        // Flush blocks a grant on an idle unit
        nxt(); req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; flush = 1'b1; mid();
        check("fl_idle_block", 32'(req0_ready), 32'd0);
        nxt(); flush = 1'b0; mid();
        check("fl_idle_grant", 32'({req0_ready, dp_issue}), 32'b10);
        nxt(); req0_valid = 1'b0;
        wait_idle("fl_idle2");

        // Asynchronous reset mid-pipeline
        nxt(); req0_valid = 1'b1; req0_a = 8'h0C; req0_b = 8'h03; mid();
        check("ar_acc", 32'(req0_ready), 32'd1);
        nxt(); req0_valid = 1'b0; #1;
        check("ar_pre", 32'(dp_issue), 32'd1);
        rst_n = 1'b0; #1;
        check("ar_clear", 32'({dp_issue, idle, dp_a}), 32'({1'b0, 1'b1, 8'h00}));
        mid();
        nxt(); rst_n = 1'b1;
        nxt(); req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; mid();
        check("ar_acc2", 32'(req0_ready), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            nxt(); req0_valid = 1'b0; mid();
            if (c < 4) check("ar_lat_wait", 32'(rsp0_valid), 32'd0);
            else       check("ar_lat", 32'({rsp0_valid, rsp0_data}), 32'({1'b1, 8'h06}));
        end
        wait_idle("ar_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
